// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg
//   Shared definitions for the UART transaction scheduler: FSM state
//   encoding, field widths and a one-hot to index helper.
package uart_sched_pkg;

  localparam int CFG_W  = 24;  // {CtrlReg1, CtrlReg2, CtrlReg3}
  localparam int LEN_W  = 8;   // tx / rsp byte counts
  localparam int BYTE_W = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GRANT = 3'd1;
  localparam logic [2:0] ST_CFG   = 3'd2;
  localparam logic [2:0] ST_CLR   = 3'd3;
  localparam logic [2:0] ST_SEND  = 3'd4;
  localparam logic [2:0] ST_RECV  = 3'd5;
  localparam logic [2:0] ST_FIN   = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT,
    CFG   = ST_CFG,
    CLR   = ST_CLR,
    SEND  = ST_SEND,
    RECV  = ST_RECV,
    FIN   = ST_FIN
  } sched_state_t;

  // Index of the set bit in a one-hot vector of up to 8 requesters.
  function automatic logic [2:0] oh_index(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: the first set request at or after
//   ptr wins, wrapping to the lowest index when nothing is set above it.
//   Ports: req (request vector), ptr (priority start index),
//          gnt (one-hot winner, 0 when req is 0).
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt
);

  logic [NREQ-1:0] hi_mask_s;
  logic [NREQ-1:0] masked_s;
  logic [NREQ-1:0] pick_s;

  // Thermometer mask selecting indices at or above the pointer.
  always_comb begin
    hi_mask_s = '0;
    for (int j = 0; j < NREQ; j++) begin
      hi_mask_s[j] = (PTR_W'(j) >= ptr);
    end
  end

  assign masked_s = req & hi_mask_s;
  assign pick_s   = (masked_s != '0) ? masked_s : req;
  // Isolate the lowest set bit of the chosen vector.
  assign gnt      = pick_s & (~pick_s + NREQ'(1));

endmodule

// File: rtl/uart_txn_scheduler.sv
// uart_txn_scheduler
//   Shares one UartCore between NREQ requesters. A granted transaction runs
//   config write -> FIFO clear -> byte send -> response collect and ends
//   with a done or timeout pulse. All outputs are registered.
//   Requester side: req_i, cfg_i, tx_len_i, rsp_len_i, tx_byte_i in;
//                   tx_pop_o, gnt_o, rsp_data_o, rsp_vld_o, done_o, tmo_o out.
//   UartCore side:  p_We_o, CtrlReg1/2/3_o, n_clr_o, uart_data_o, n_we_o,
//                   n_rd_o out; p_full_i, uart_data_i, p_empty_i in.
module uart_txn_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TMO_W   = 24,
  parameter int TMO_CYC = 4000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*CFG_W-1:0] cfg_i,
  input  logic [NREQ*LEN_W-1:0] tx_len_i,
  input  logic [NREQ*LEN_W-1:0] rsp_len_i,
  input  logic [NREQ*8-1:0]     tx_byte_i,
  output logic [NREQ-1:0]       tx_pop_o,
  output logic [NREQ-1:0]       gnt_o,
  output logic [7:0]            rsp_data_o,
  output logic                  rsp_vld_o,
  output logic [NREQ-1:0]       done_o,
  output logic [NREQ-1:0]       tmo_o,
  output logic                  p_We_o,
  output logic [7:0]            CtrlReg1_o,
  output logic [7:0]            CtrlReg2_o,
  output logic [7:0]            CtrlReg3_o,
  output logic                  n_clr_o,
  output logic [7:0]            uart_data_o,
  output logic                  n_we_o,
  input  logic                  p_full_i,
  input  logic [7:0]            uart_data_i,
  output logic                  n_rd_o,
  input  logic                  p_empty_i
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [CFG_W-1:0]  cfg_a     [NREQ];
  logic [LEN_W-1:0]  tx_len_a  [NREQ];
  logic [LEN_W-1:0]  rsp_len_a [NREQ];
  logic [BYTE_W-1:0] tx_byte_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign cfg_a[g]     = cfg_i[g*CFG_W +: CFG_W];
    assign tx_len_a[g]  = tx_len_i[g*LEN_W +: LEN_W];
    assign rsp_len_a[g] = rsp_len_i[g*LEN_W +: LEN_W];
    assign tx_byte_a[g] = tx_byte_i[g*BYTE_W +: BYTE_W];
  end

  sched_state_t      state_r, state_s;
  logic [PTR_W-1:0]  ptr_r, ptr_s, owner_r, owner_s, arb_idx_s;
  logic [NREQ-1:0]   arb_gnt_s;
  logic [NREQ-1:0]   gnt_r, gnt_s, tx_pop_r, tx_pop_s;
  logic [NREQ-1:0]   done_r, done_s, tmo_r, tmo_s;
  logic [LEN_W-1:0]  tx_len_r, tx_len_s, rsp_len_r, rsp_len_s;
  logic [LEN_W-1:0]  wr_cnt_r, wr_cnt_s, rd_cnt_r, rd_cnt_s;
  logic [TMO_W-1:0]  tmo_cnt_r, tmo_cnt_s;
  logic [7:0]        ctrl1_r, ctrl1_s, ctrl2_r, ctrl2_s, ctrl3_r, ctrl3_s;
  logic [7:0]        uart_data_r, uart_data_s, rsp_data_r, rsp_data_s;
  logic              p_we_r, p_we_s, n_clr_r, n_clr_s, n_we_r, n_we_s;
  logic              n_rd_r, n_rd_s, rsp_vld_r, rsp_vld_s, rd_dly_r, rd_dly_s;

  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
    .req (req_i),
    .ptr (ptr_r),
    .gnt (arb_gnt_s)
  );

  assign arb_idx_s = PTR_W'(oh_index(8'(arb_gnt_s)));

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    owner_s     = owner_r;
    gnt_s       = gnt_r;
    tx_len_s    = tx_len_r;
    rsp_len_s   = rsp_len_r;
    wr_cnt_s    = wr_cnt_r;
    rd_cnt_s    = rd_cnt_r;
    tmo_cnt_s   = tmo_cnt_r;
    ctrl1_s     = ctrl1_r;
    ctrl2_s     = ctrl2_r;
    ctrl3_s     = ctrl3_r;
    uart_data_s = uart_data_r;
    rsp_data_s  = rsp_data_r;
    p_we_s      = 1'b0;
    n_clr_s     = 1'b1;
    n_we_s      = 1'b1;
    n_rd_s      = 1'b1;
    tx_pop_s    = '0;
    done_s      = '0;
    tmo_s       = '0;
    rsp_vld_s   = 1'b0;
    // A read strobe this cycle means the byte is on uart_data_i next cycle.
    rd_dly_s    = ~n_rd_r;

    case (state_r)
      IDLE: begin
        if (req_i != '0) begin
          state_s = GRANT;
          gnt_s   = arb_gnt_s;
          owner_s = arb_idx_s;
          ptr_s   = (arb_idx_s == PTR_W'(NREQ - 1)) ? '0 : arb_idx_s + PTR_W'(1);
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        ctrl1_s   = cfg_a[owner_r][23:16];
        ctrl2_s   = cfg_a[owner_r][15:8];
        ctrl3_s   = cfg_a[owner_r][7:0];
        tx_len_s  = tx_len_a[owner_r];
        rsp_len_s = rsp_len_a[owner_r];
        p_we_s    = 1'b1;
        state_s   = CFG;
      end
      CFG: begin
        n_clr_s = 1'b0;
        state_s = CLR;
      end
      CLR: begin
        wr_cnt_s  = '0;
        rd_cnt_s  = '0;
        tmo_cnt_s = '0;
        if (tx_len_r != '0) begin
          state_s = SEND;
        end else if (rsp_len_r != '0) begin
          state_s = RECV;
        end else begin
          state_s = FIN;
          done_s  = gnt_r;
        end
      end
      SEND: begin
        tmo_cnt_s = '0;
        if (wr_cnt_r == tx_len_r) begin
          if (rsp_len_r == '0) begin
            state_s = FIN;
            done_s  = gnt_r;
          end else begin
            state_s = RECV;
          end
        end else if (!p_full_i && n_we_r) begin
          // n_we_r low blocks back-to-back writes so p_full_i can settle
          // and the requester can present its next byte after the pop.
          n_we_s      = 1'b0;
          tx_pop_s    = gnt_r;
          uart_data_s = tx_byte_a[owner_r];
          wr_cnt_s    = wr_cnt_r + LEN_W'(1);
        end else begin
          state_s = SEND;
        end
      end
      RECV: begin
        tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
        if (rd_dly_r) begin
          // Byte arrival beats a coincident timeout.
          rsp_data_s = uart_data_i;
          rsp_vld_s  = 1'b1;
          rd_cnt_s   = rd_cnt_r + LEN_W'(1);
          tmo_cnt_s  = '0;
          if ((rd_cnt_r + LEN_W'(1)) == rsp_len_r) begin
            state_s = FIN;
            done_s  = gnt_r;
          end else begin
            state_s = RECV;
          end
        end else if (tmo_cnt_r == TMO_W'(TMO_CYC - 1)) begin
          state_s = FIN;
          tmo_s   = gnt_r;
        end else if (!p_empty_i && n_rd_r && (rd_cnt_r < rsp_len_r)) begin
          n_rd_s = 1'b0;
        end else begin
          state_s = RECV;
        end
      end
      FIN: begin
        gnt_s   = '0;
        state_s = IDLE;
      end
      default: begin
        gnt_s   = '0;
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      owner_r     <= '0;
      gnt_r       <= '0;
      tx_len_r    <= '0;
      rsp_len_r   <= '0;
      wr_cnt_r    <= '0;
      rd_cnt_r    <= '0;
      tmo_cnt_r   <= '0;
      ctrl1_r     <= 8'h00;
      ctrl2_r     <= 8'h00;
      ctrl3_r     <= 8'h00;
      uart_data_r <= 8'h00;
      rsp_data_r  <= 8'h00;
      p_we_r      <= 1'b0;
      n_clr_r     <= 1'b1;
      n_we_r      <= 1'b1;
      n_rd_r      <= 1'b1;
      tx_pop_r    <= '0;
      done_r      <= '0;
      tmo_r       <= '0;
      rsp_vld_r   <= 1'b0;
      rd_dly_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      owner_r     <= owner_s;
      gnt_r       <= gnt_s;
      tx_len_r    <= tx_len_s;
      rsp_len_r   <= rsp_len_s;
      wr_cnt_r    <= wr_cnt_s;
      rd_cnt_r    <= rd_cnt_s;
      tmo_cnt_r   <= tmo_cnt_s;
      ctrl1_r     <= ctrl1_s;
      ctrl2_r     <= ctrl2_s;
      ctrl3_r     <= ctrl3_s;
      uart_data_r <= uart_data_s;
      rsp_data_r  <= rsp_data_s;
      p_we_r      <= p_we_s;
      n_clr_r     <= n_clr_s;
      n_we_r      <= n_we_s;
      n_rd_r      <= n_rd_s;
      tx_pop_r    <= tx_pop_s;
      done_r      <= done_s;
      tmo_r       <= tmo_s;
      rsp_vld_r   <= rsp_vld_s;
      rd_dly_r    <= rd_dly_s;
    end
  end

  assign gnt_o       = gnt_r;
  assign tx_pop_o    = tx_pop_r;
  assign done_o      = done_r;
  assign tmo_o       = tmo_r;
  assign rsp_data_o  = rsp_data_r;
  assign rsp_vld_o   = rsp_vld_r;
  assign p_We_o      = p_we_r;
  assign CtrlReg1_o  = ctrl1_r;
  assign CtrlReg2_o  = ctrl2_r;
  assign CtrlReg3_o  = ctrl3_r;
  assign n_clr_o     = n_clr_r;
  assign uart_data_o = uart_data_r;
  assign n_we_o      = n_we_r;
  assign n_rd_o      = n_rd_r;

endmodule

// File: tb/tb_uart_txn_scheduler.sv
// tb_uart_txn_scheduler
//   Directed bench for uart_txn_scheduler with a small UartCore FIFO model
//   and requester byte sources driven at the falling clock edge.
module tb_uart_txn_scheduler;

  logic        clk;
  logic        rst;
  logic [1:0]  req_i;
  logic [47:0] cfg_i;
  logic [15:0] tx_len_i;
  logic [15:0] rsp_len_i;
  logic [15:0] tx_byte_i;
  logic [1:0]  tx_pop_o;
  logic [1:0]  gnt_o;
  logic [7:0]  rsp_data_o;
  logic        rsp_vld_o;
  logic [1:0]  done_o;
  logic [1:0]  tmo_o;
  logic        p_We_o;
  logic [7:0]  CtrlReg1_o, CtrlReg2_o, CtrlReg3_o;
  logic        n_clr_o;
  logic [7:0]  uart_data_o;
  logic        n_we_o;
  logic        p_full_i;
  logic [7:0]  uart_data_i;
  logic        n_rd_o;
  logic        p_empty_i;

  uart_txn_scheduler #(.NREQ(2), .TMO_W(24), .TMO_CYC(100)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .cfg_i       (cfg_i),
    .tx_len_i    (tx_len_i),
    .rsp_len_i   (rsp_len_i),
    .tx_byte_i   (tx_byte_i),
    .tx_pop_o    (tx_pop_o),
    .gnt_o       (gnt_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_vld_o   (rsp_vld_o),
    .done_o      (done_o),
    .tmo_o       (tmo_o),
    .p_We_o      (p_We_o),
    .CtrlReg1_o  (CtrlReg1_o),
    .CtrlReg2_o  (CtrlReg2_o),
    .CtrlReg3_o  (CtrlReg3_o),
    .n_clr_o     (n_clr_o),
    .uart_data_o (uart_data_o),
    .n_we_o      (n_we_o),
    .p_full_i    (p_full_i),
    .uart_data_i (uart_data_i),
    .n_rd_o      (n_rd_o),
    .p_empty_i   (p_empty_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  logic [7:0] rx_plan[$];
  logic [7:0] tx_log[$];
  logic [7:0] rsp_log[$];
  int         tx_cyc[$];
  int         rsp_cyc[$];
  logic [1:0] gnt_log[$];
  logic [1:0] gnt_prev = 2'b00;
  logic [1:0] done_who, tmo_who;
  int grant_cyc, done_cyc, tmo_cyc;
  int pwe_cnt, nclr_cnt, done_cnt, tmo_cnt, full_viol, full_cnt;
  int multi_gnt = 0;
  bit full_arm;
  logic [7:0] tx_data [2][8];
  int tx_idx [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_tx();
    tx_byte_i[7:0]  = tx_data[0][tx_idx[0] % 8];
    tx_byte_i[15:8] = tx_data[1][tx_idx[1] % 8];
  endtask

  task automatic clear_logs();
    tx_log.delete(); rsp_log.delete(); tx_cyc.delete(); rsp_cyc.delete(); gnt_log.delete();
    pwe_cnt = 0; nclr_cnt = 0; done_cnt = 0; tmo_cnt = 0; full_viol = 0;
    done_who = 2'b00; tmo_who = 2'b00; grant_cyc = 0; done_cyc = 0; tmo_cyc = 0;
  endtask

  task automatic set_req(input int r, input logic [23:0] cfg, input logic [7:0] tl, input logic [7:0] rl,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    cfg_i[r*24 +: 24]   = cfg;
    tx_len_i[r*8 +: 8]  = tl;
    rsp_len_i[r*8 +: 8] = rl;
    tx_data[r][0] = b0; tx_data[r][1] = b1; tx_data[r][2] = b2; tx_data[r][3] = b3;
    tx_idx[r] = 0;
    drive_tx();
  endtask

  // One clock: observe outputs at the falling edge, then update the models.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if ($countones(gnt_o) > 1) multi_gnt++;
    if (gnt_o != 2'b00 && gnt_prev == 2'b00) begin
      gnt_log.push_back(gnt_o);
      grant_cyc = cyc;
    end
    gnt_prev = gnt_o;
    if (p_We_o) pwe_cnt++;
    if (!n_clr_o) begin
      nclr_cnt++;
      rx_q = rx_plan;
    end
    if (!n_we_o) begin
      if (p_full_i) full_viol++;
      tx_log.push_back(uart_data_o);
      tx_cyc.push_back(cyc);
    end
    if (rsp_vld_o) begin
      rsp_log.push_back(rsp_data_o);
      rsp_cyc.push_back(cyc);
    end
    if (done_o != 2'b00) begin
      done_cnt++; done_who = done_o; done_cyc = cyc;
      req_i = req_i & ~done_o;
    end
    if (tmo_o != 2'b00) begin
      tmo_cnt++; tmo_who = tmo_o; tmo_cyc = cyc;
      req_i = req_i & ~tmo_o;
    end
    for (int r = 0; r < 2; r++) begin
      if (tx_pop_o[r]) tx_idx[r]++;
    end
    if (!n_rd_o && rx_q.size() > 0) uart_data_i = rx_q.pop_front();
    p_empty_i = (rx_q.size() == 0);
    if (full_cnt > 0) begin
      full_cnt--;
      if (full_cnt == 0) p_full_i = 1'b0;
    end
    if (!n_we_o && full_arm) begin
      p_full_i = 1'b1;
      full_cnt = 50;
      full_arm = 1'b0;
    end
    drive_tx();
  endtask

  task automatic wait_ends(input int n, input int budget, input string tag);
    int b;
    b = budget;
    while ((done_cnt + tmo_cnt) < n && b > 0) begin
      tick();
      b--;
    end
    chk(tag, 32'(done_cnt + tmo_cnt), 32'(n));
  endtask

  initial begin
    rst = 1'b0; req_i = 2'b00; cfg_i = '0; tx_len_i = '0; rsp_len_i = '0; tx_byte_i = '0;
    p_full_i = 1'b0; uart_data_i = 8'h00; p_empty_i = 1'b1; full_arm = 1'b0; full_cnt = 0;
    tx_idx[0] = 0; tx_idx[1] = 0;
    for (int r = 0; r < 2; r++) for (int i = 0; i < 8; i++) tx_data[r][i] = 8'h00;
    clear_logs();
    repeat (3) tick();
    // Reset values
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_n_clr", 32'(n_clr_o), 32'h1);
    chk("rst_n_we", 32'(n_we_o), 32'h1);
    chk("rst_n_rd", 32'(n_rd_o), 32'h1);
    chk("rst_p_we", 32'(p_We_o), 32'h0);
    chk("rst_ctrl1", 32'(CtrlReg1_o), 32'h0);
    rst = 1'b1;
    repeat (2) tick();

    // Test 1: basic transaction on req0
    clear_logs();
    set_req(0, 24'hC00103, 8'd3, 8'd2, 8'hA1, 8'hB2, 8'hC3, 8'h00);
    rx_plan = '{8'h55, 8'h66};
    req_i = 2'b01;
    wait_ends(1, 200, "t1_end");
    chk("t1_done_who", 32'(done_who), 32'h1);
    chk("t1_tmo", 32'(tmo_cnt), 32'h0);
    chk("t1_pwe", 32'(pwe_cnt), 32'h1);
    chk("t1_nclr", 32'(nclr_cnt), 32'h1);
    chk("t1_ntx", 32'(tx_log.size()), 32'h3);
    chk("t1_tx0", 32'(tx_log[0]), 32'hA1);
    chk("t1_tx1", 32'(tx_log[1]), 32'hB2);
    chk("t1_tx2", 32'(tx_log[2]), 32'hC3);
    chk("t1_first_wr_lat", 32'(tx_cyc[0] - grant_cyc), 32'd4);
    chk("t1_gap01", 32'(tx_cyc[1] - tx_cyc[0]), 32'd2);
    chk("t1_gap12", 32'(tx_cyc[2] - tx_cyc[1]), 32'd2);
    chk("t1_nrsp", 32'(rsp_log.size()), 32'h2);
    chk("t1_rsp0", 32'(rsp_log[0]), 32'h55);
    chk("t1_rsp1", 32'(rsp_log[1]), 32'h66);
    chk("t1_done_lat", 32'(done_cyc - grant_cyc), 32'd15);
    chk("t1_ctrl1", 32'(CtrlReg1_o), 32'hC0);
    chk("t1_ctrl2", 32'(CtrlReg2_o), 32'h01);
    chk("t1_ctrl3", 32'(CtrlReg3_o), 32'h03);
    tick();
    chk("t1_gnt_clear", 32'(gnt_o), 32'h0);

    // Test 2: both requesters, twice, from a fresh pointer
    rst = 1'b0; tick(); rst = 1'b1; tick();
    clear_logs();
    rx_plan = {};
    set_req(0, 24'h000000, 8'd0, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    set_req(1, 24'h111111, 8'd0, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    req_i = 2'b11;
    wait_ends(2, 100, "t2_round1");
    req_i = 2'b11;
    wait_ends(4, 100, "t2_round2");
    chk("t2_ngnt", 32'(gnt_log.size()), 32'h4);
    chk("t2_g0", 32'(gnt_log[0]), 32'h1);
    chk("t2_g1", 32'(gnt_log[1]), 32'h2);
    chk("t2_g2", 32'(gnt_log[2]), 32'h1);
    chk("t2_g3", 32'(gnt_log[3]), 32'h2);
    tick();

    // Test 3: FIFO full after the first byte
    clear_logs();
    set_req(1, 24'h020304, 8'd4, 8'd0, 8'h11, 8'h22, 8'h33, 8'h44);
    full_arm = 1'b1;
    req_i = 2'b10;
    wait_ends(1, 300, "t3_end");
    chk("t3_done_who", 32'(done_who), 32'h2);
    chk("t3_full_viol", 32'(full_viol), 32'h0);
    chk("t3_ntx", 32'(tx_log.size()), 32'h4);
    chk("t3_tx0", 32'(tx_log[0]), 32'h11);
    chk("t3_tx1", 32'(tx_log[1]), 32'h22);
    chk("t3_tx2", 32'(tx_log[2]), 32'h33);
    chk("t3_tx3", 32'(tx_log[3]), 32'h44);
    chk("t3_stall_gap", 32'(tx_cyc[1] - tx_cyc[0]), 32'd51);
    tick();

    // Test 4: response timeout after two of four bytes
    clear_logs();
    set_req(0, 24'h0A0B0C, 8'd1, 8'd4, 8'h77, 8'h00, 8'h00, 8'h00);
    rx_plan = '{8'h12, 8'h34};
    req_i = 2'b01;
    wait_ends(1, 400, "t4_end");
    chk("t4_tmo_who", 32'(tmo_who), 32'h1);
    chk("t4_done", 32'(done_cnt), 32'h0);
    chk("t4_nrsp", 32'(rsp_log.size()), 32'h2);
    chk("t4_rsp1", 32'(rsp_log[1]), 32'h34);
    chk("t4_tmo_lat", 32'(tmo_cyc - rsp_cyc[1]), 32'd100);
    tick();

    // Test 5: empty transaction
    clear_logs();
    rx_plan = {};
    set_req(1, 24'h050607, 8'd0, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    req_i = 2'b10;
    wait_ends(1, 50, "t5_end");
    chk("t5_done_who", 32'(done_who), 32'h2);
    chk("t5_done_lat", 32'(done_cyc - grant_cyc), 32'd3);
    chk("t5_pwe", 32'(pwe_cnt), 32'h1);
    chk("t5_nclr", 32'(nclr_cnt), 32'h1);
    chk("t5_ntx", 32'(tx_log.size()), 32'h0);
    tick();

    // Test 6: reset during SEND
    clear_logs();
    set_req(0, 24'h123456, 8'd3, 8'd1, 8'hD1, 8'hD2, 8'hD3, 8'h00);
    rx_plan = '{8'h99};
    req_i = 2'b01;
    for (int b = 0; b < 40 && tx_log.size() < 1; b++) tick();
    chk("t6_in_send", 32'(tx_log.size()), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("t6_gnt", 32'(gnt_o), 32'h0);
    chk("t6_n_we", 32'(n_we_o), 32'h1);
    chk("t6_udata", 32'(uart_data_o), 32'h0);
    chk("t6_ctrl1", 32'(CtrlReg1_o), 32'h0);
    chk("t6_pop", 32'(tx_pop_o), 32'h0);
    chk("t6_rsp_data", 32'(rsp_data_o), 32'h0);
    req_i = 2'b00;
    clear_logs();
    repeat (3) tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("t6_no_end", 32'(done_cnt + tmo_cnt), 32'h0);
    set_req(0, 24'h000000, 8'd0, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    set_req(1, 24'h000000, 8'd0, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    req_i = 2'b11;
    wait_ends(2, 100, "t6_after");
    chk("t6_first_gnt", 32'(gnt_log[0]), 32'h1);
    chk("t6_second_gnt", 32'(gnt_log[1]), 32'h2);
    chk("multi_gnt", 32'(multi_gnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
